ad9122_cfg_seq: RTL

- Power-up/reconfiguration sequencer for the AD9122 DAC.
- Walks a configuration table of NUM_REGS entries and drives the SPI master's write_req/read_req one transaction at a time, waiting for each completion pulse.
- Verify-flagged entries are read back and compared, with bounded retry.
- Sits between the system control FSM (start/done/err) and the 3-wire SPI master, which it owns exclusively.

---
 rtl/ad9122_cfg_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ad9122_cfg_seq.sv
// AD9122 power-up / reconfiguration sequencer.
// Walks the register table over SPI, with verify readback and bounded retry.
module ad9122_cfg_seq #(
  parameter int NUM_REGS  = 32,
  parameter int IDX_W     = 5,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 1023,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [16:0]      tbl_data,
  output logic [7:0]       spi_addr,
  output logic [7:0]       spi_wdata,
  output logic             spi_write_req,
  output logic             spi_read_req,
  input  logic [7:0]       spi_rdata,
  input  logic             spi_done,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [IDX_W-1:0] err_idx,
  output logic [7:0]       err_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR, S_WR_WAIT, S_RD,
    S_RD_WAIT, S_CHECK, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic [RW-1:0] retry;
  logic [7:0]    rdbk;
  logic          vfy;
  logic          rpend;

  logic tmo_hit, gap_last, last_idx, match, can_retry;

  assign tmo_hit   = (tcnt == TW'(TIMEOUT));
  assign gap_last  = (gcnt == GW'(GAP_CYC - 1));
  assign last_idx  = (tbl_idx == IDX_W'(NUM_REGS - 1));
  assign match     = (rdbk == spi_wdata);
  assign can_retry = (retry < RW'(MAX_RETRY));

  always_comb begin
    state_d       = state_q;
    spi_write_req = 1'b0;
    spi_read_req  = 1'b0;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   state_d = S_WR;
      S_WR: begin
        spi_write_req = 1'b1;
        state_d       = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (spi_done)     state_d = vfy ? S_RD : S_GAP;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_RD: begin
        spi_read_req = 1'b1;
        state_d      = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (spi_done)     state_d = S_CHECK;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_CHECK: begin
        if (match || can_retry) state_d = S_GAP;
        else                    state_d = S_ERR;
      end
      S_GAP: begin
        if (gap_last) begin
          if (rpend)         state_d = S_WR;
          else if (last_idx) state_d = S_DONE;
          else               state_d = S_FETCH;
        end
      end
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      tbl_idx   <= '0;
      spi_addr  <= '0;
      spi_wdata <= '0;
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_idx   <= '0;
      err_rdata <= '0;
      tcnt      <= '0;
      gcnt      <= '0;
      retry     <= '0;
      rdbk      <= '0;
      vfy       <= 1'b0;
      rpend     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            tbl_idx  <= '0;
            retry    <= '0;
            rpend    <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          spi_addr  <= tbl_data[15:8];
          spi_wdata <= tbl_data[7:0];
          vfy       <= tbl_data[16];
        end
        // readback is cleared per request so a timeout reports 0
        S_WR, S_RD: begin
          tcnt <= '0;
          rdbk <= '0;
        end
        S_WR_WAIT, S_RD_WAIT: begin
          if (spi_done && state_q == S_RD_WAIT) rdbk <= spi_rdata;
          if (!tmo_hit) tcnt <= tcnt + 1'b1;
        end
        S_CHECK: begin
          if (match) begin
            retry <= '0;
          end else if (can_retry) begin
            retry <= retry + 1'b1;
            rpend <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_last) begin
            gcnt  <= '0;
            rpend <= 1'b0;
            if (!rpend && !last_idx) tbl_idx <= tbl_idx + 1'b1;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        S_DONE: begin
          cfg_done <= 1'b1;
          busy     <= 1'b0;
        end
        S_ERR: begin
          cfg_err   <= 1'b1;
          err_idx   <= tbl_idx;
          err_rdata <= rdbk;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
